// File: rtl/hd_fifo_if.sv
// Valid/ready bundle between the HD stage, the elastic FIFO and its consumer.
// The slave modport is the FIFO's view; the master modport is the view of the surrounding logic.
interface hd_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  valid;
  logic [DATA_WIDTH-1:0] data_src;
  logic                  ready_output;
  logic                  valid_output;
  logic [DATA_WIDTH-1:0] data_dest;
  logic                  ready;
  logic [ADDR_W:0]       count;

  modport slave (
    input  valid, data_src, ready,
    output ready_output, valid_output, data_dest, count
  );

  modport master (
    output valid, data_src, ready,
    input  ready_output, valid_output, data_dest, count
  );
endinterface

// File: rtl/hd_fifo.sv
// First-word-fall-through elastic buffer behind the HD handshake stage.
// It absorbs consumer back-pressure. All outputs decode registered state only.
module hd_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic     clk,
  input  logic     rst,
  hd_fifo_if.slave bus
);
  localparam int              ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] EMPTY_CNT = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0] ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  push_s;
  logic                  pop_s;

  // Handshake decode, pointer and occupancy next-state, storage write.
  always_comb begin
    push_s   = rst & bus.valid & (count_q != FULL_CNT);
    pop_s    = rst & bus.ready & (count_q != EMPTY_CNT);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = bus.data_src;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Push and pop together leave occupancy unchanged.
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous active-low reset; words are discarded without draining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      count_q  <= EMPTY_CNT;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.valid_output = (count_q != EMPTY_CNT);
  assign bus.ready_output = (count_q != FULL_CNT);
  assign bus.data_dest    = mem_q[rd_ptr_q];
  assign bus.count        = count_q;
endmodule
